// File: rtl/write_rw.sv
// write_rw: applies the min-update rule to one RW object at a time, writes the changed
// word into its lane of a 64B L2 line, then hands a finish record downstream.
module write_rw #(
    parameter int TILE_ID      = 0,
    parameter int LOG_RW_WIDTH = 2,
    localparam int OW          = 8 << LOG_RW_WIDTH,
    localparam int TASK_W      = 68,
    localparam int IN_W        = TASK_W + 8 + 4 + OW + 14
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              task_in_valid,
    output logic              task_in_ready,
    input  logic [IN_W-1:0]   task_in,
    output logic              wvalid,
    input  logic              wready,
    output logic [31:0]       waddr,
    output logic [511:0]      wdata,
    output logic [63:0]       wstrb,
    output logic [3:0]        wid,
    output logic              finish_valid,
    input  logic              finish_ready,
    output logic [3:0]        finish_thread,
    output logic [7:0]        finish_slot,
    output logic [TASK_W-1:0] finish_task,
    output logic              finish_wrote,
    input  logic              reg_bus_wen,
    input  logic              reg_bus_ren,
    input  logic [15:0]       reg_bus_addr,
    input  logic [31:0]       reg_bus_wdata,
    output logic              reg_bus_rvalid,
    output logic [31:0]       reg_bus_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DECIDE = 2'd1;
    localparam logic [1:0] WRITE  = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    localparam logic [3:0] TASK_TYPE_UNDO_LOG_RESTORE = 4'hF;

    localparam logic [7:0] RW_BASE_ADDR  = 8'h10;
    localparam logic [7:0] CORE_N_WRITES = 8'h20;
    localparam logic [7:0] CORE_N_SKIPS  = 8'h24;

    localparam int OB       = OW / 8;
    localparam int OBJ_LSB  = 14;
    localparam int THR_LSB  = OBJ_LSB + OW;
    localparam int SLOT_LSB = THR_LSB + 4;
    localparam int TASK_LSB = SLOT_LSB + 8;

    localparam logic [63:0] STRB_ONES = 64'((65'd1 << OB) - 65'd1);
    localparam logic [5:0]  LANE_MASK = ~6'(OB - 1);

    logic [1:0]        state;
    logic [TASK_W-1:0] hold_task;
    logic [7:0]        hold_slot;
    logic [3:0]        hold_thread;
    logic [OW-1:0]     hold_obj;
    logic              upd;

    logic [31:0] base_rw_addr;
    logic [31:0] n_writes;
    logic [31:0] n_skips;

    logic [3:0]    hold_ttype;
    logic [31:0]   hold_ts;
    logic [31:0]   hold_locale;
    logic          upd_next;
    logic [OW-1:0] new_obj;
    logic [31:0]   rw_addr;
    logic [5:0]    byte_off;
    logic [511:0]  line_data;
    logic [63:0]   line_strb;

    logic       tile_hit;
    logic [7:0] reg_index;
    logic       unused_bits;

    // Task descriptor layout: {ttype[3:0], ts[31:0], locale[31:0]}
    assign hold_ttype  = hold_task[TASK_W-1 -: 4];
    assign hold_ts     = hold_task[63:32];
    assign hold_locale = hold_task[31:0];

    assign tile_hit    = (reg_bus_addr[15:8] == 8'(TILE_ID));
    assign reg_index   = reg_bus_addr[7:0];
    assign unused_bits = ^{reg_bus_wdata[31:30], task_in[OBJ_LSB-1:0]};

    always_comb begin
        upd_next = 1'b0;
        new_obj  = hold_obj;
        if (hold_ttype == TASK_TYPE_UNDO_LOG_RESTORE) begin
            upd_next = 1'b1;
        end else if (hold_ts < hold_obj[31:0]) begin
            upd_next     = 1'b1;
            new_obj[31:0] = hold_ts;
        end
    end

    // Sub-object address bits are masked so a misaligned base still selects one lane
    always_comb begin
        rw_addr   = base_rw_addr + (hold_locale << LOG_RW_WIDTH);
        byte_off  = rw_addr[5:0] & LANE_MASK;
        line_data = 512'(new_obj) << {byte_off, 3'b000};
        line_strb = STRB_ONES << byte_off;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            upd         <= 1'b0;
            hold_task   <= '0;
            hold_slot   <= '0;
            hold_thread <= '0;
            hold_obj    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (task_in_valid) begin
                        hold_task   <= task_in[TASK_LSB +: TASK_W];
                        hold_slot   <= task_in[SLOT_LSB +: 8];
                        hold_thread <= task_in[THR_LSB +: 4];
                        hold_obj    <= task_in[OBJ_LSB +: OW];
                        state       <= DECIDE;
                    end
                end
                DECIDE: begin
                    upd   <= upd_next;
                    state <= upd_next ? WRITE : FINISH;
                end
                WRITE: begin
                    if (wready) state <= FINISH;
                end
                FINISH: begin
                    if (finish_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write channel payload is registered in DECIDE so it cannot move while stalled
    always_ff @(posedge clk) begin
        if (!rstn) begin
            waddr <= '0;
            wdata <= '0;
            wstrb <= '0;
        end else if (state == DECIDE && upd_next) begin
            waddr <= {rw_addr[31:6], 6'b000000};
            wdata <= line_data;
            wstrb <= line_strb;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            n_writes <= '0;
            n_skips  <= '0;
        end else begin
            if (state == WRITE && wready) n_writes <= n_writes + 32'd1;
            if (state == FINISH && finish_ready && !upd) n_skips <= n_skips + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            base_rw_addr   <= '0;
            reg_bus_rvalid <= 1'b0;
            reg_bus_rdata  <= '0;
        end else begin
            if (reg_bus_wen && tile_hit && reg_index == RW_BASE_ADDR)
                base_rw_addr <= {reg_bus_wdata[29:0], 2'b00};
            reg_bus_rvalid <= reg_bus_ren;
            reg_bus_rdata  <= '0;
            if (reg_bus_ren && tile_hit) begin
                case (reg_index)
                    CORE_N_WRITES: reg_bus_rdata <= n_writes;
                    CORE_N_SKIPS:  reg_bus_rdata <= n_skips;
                    default:       reg_bus_rdata <= '0;
                endcase
            end
        end
    end

    assign task_in_ready = rstn && (state == IDLE);
    assign wvalid        = (state == WRITE);
    assign finish_valid  = (state == FINISH);
    assign wid           = hold_thread;
    assign finish_thread = hold_thread;
    assign finish_slot   = hold_slot;
    assign finish_task   = hold_task;
    assign finish_wrote  = upd;

endmodule
